// File: rtl/pmem_arbiter_rr_pkg.sv
// mem_arb_pkg: shared state type and geometry helpers for the pmem arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BURST, DONE} arb_state_t;
    function automatic int beats(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction
    function automatic int offset_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction
endpackage

// File: rtl/pmem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select starting after last_grant
module rr_pick #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [IDX_W-1:0]  grant,
    output logic              any_req
);
    logic [IDX_W-1:0] idx;
    // Scan farthest-first so the nearest requester after last_grant wins.
    always_comb begin
        grant = '0;
        idx = '0;
        any_req = |req;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_CH);
            if (req[idx]) grant = idx;
        end
    end
endmodule

// File: rtl/pmem_arbiter_rr.sv
// pmem_arbiter_rr: N-channel round-robin cacheline-to-burst pmem arbiter
module pmem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [BEAT_W-1:0]        pmem_wdata,
    input  logic [BEAT_W-1:0]        pmem_rdata,
    input  logic                     pmem_resp
);
    localparam int BEATS = beats(LINE_W, BEAT_W);
    localparam int OFF_W = offset_w(LINE_W);
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    arb_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  last_grant, grant, pick;
    logic              any_req, op_write, last_beat;
    logic [ADDR_W-1:0] addr, sel_addr;
    logic [LINE_W-1:0] wline, rline;

    rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
        .req       (ch_read | ch_write),
        .last_grant(last_grant),
        .grant     (pick),
        .any_req   (any_req)
    );

    assign sel_addr  = ch_address[int'(pick)*ADDR_W +: ADDR_W];
    assign last_beat = pmem_resp && cnt == CNT_W'(BEATS - 1);

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_next;

    always_comb begin
        state_next = state == IDLE  ? (any_req ? BURST : IDLE) :
                     state == BURST ? (last_beat ? DONE : BURST) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            last_grant <= IDX_W'(NUM_CH - 1);
            grant      <= '0;
            op_write   <= 1'b0;
            addr       <= '0;
            wline      <= '0;
            rline      <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant    <= pick;
                op_write <= ch_write[pick];
                addr     <= {sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (ch_write[pick]) wline <= ch_wdata[int'(pick)*LINE_W +: LINE_W];
            end
            if (state == BURST && pmem_resp) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
                if (!op_write) rline[int'(cnt)*BEAT_W +: BEAT_W] <= pmem_rdata;
            end
            if (state == DONE) last_grant <= grant;
        end
    end

    assign pmem_read    = state == BURST && !op_write;
    assign pmem_write   = state == BURST && op_write;
    assign pmem_address = state == BURST ? addr : '0;
    assign pmem_wdata   = pmem_write ? wline[int'(cnt)*BEAT_W +: BEAT_W] : '0;
    assign ch_resp      = state == DONE ? NUM_CH'(1) << grant : '0;
    assign ch_rdata     = rline;
endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// tb_pmem_arbiter_rr: directed self-checking bench for the 3-channel arbiter
module tb_pmem_arbiter_rr;
    localparam int NC = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   ch_read, ch_write;
    logic [NC*32-1:0]  ch_address;
    logic [NC*256-1:0] ch_wdata;
    logic [255:0]    ch_rdata;
    logic [NC-1:0]   ch_resp;
    logic            pmem_read, pmem_write, pmem_resp;
    logic [31:0]     pmem_address;
    logic [63:0]     pmem_wdata, pmem_rdata;

    int checks = 0;
    int errors = 0;

    pmem_arbiter_rr #(.NUM_CH(NC), .ADDR_W(32), .LINE_W(256), .BEAT_W(64)) dut (
        .clk(clk), .rst(rst),
        .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata),
        .ch_rdata(ch_rdata), .ch_resp(ch_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [63:0]  wb [4];
    logic [255:0] rl;

    initial begin
        wb[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        wb[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        wb[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        wb[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        rl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        rst = 1'b1; ch_read = '0; ch_write = '0; ch_address = '0; ch_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        step(); step();
        chk("rst_read", pmem_read, 0);
        chk("rst_write", pmem_write, 0);
        chk("rst_resp", ch_resp, 0);
        chk("rst_rdata", ch_rdata, 0);
        chk("rst_addr", pmem_address, 0);

        // reset mid-burst
        rst = 1'b0;
        ch_read = 3'b001; ch_address[0 +: 32] = 32'h0000_0100;
        step();
        chk("b_read", pmem_read, 1);
        chk("b_addr", pmem_address, 32'h100);
        pmem_resp = 1'b1; pmem_rdata = 64'hFFFF;
        step(); step();
        rst = 1'b1;
        step();
        chk("b_abort_read", pmem_read, 0);
        chk("b_abort_resp", ch_resp, 0);
        rst = 1'b0; ch_read = '0; pmem_resp = 1'b0;
        step();
        chk("b_no_resp", ch_resp, 0);
        chk("b_idle_read", pmem_read, 0);

        // single read ch0 with ch1 also requesting: ch0 first after reset
        ch_read = 3'b011;
        ch_address[0 +: 32] = 32'h0000_1234;
        ch_address[32 +: 32] = 32'h0000_8000;
        step();
        chk("c_addr", pmem_address, 32'h0000_1220);
        chk("c_read", pmem_read, 1);
        ch_read = 3'b001;
        for (int k = 0; k < 4; k++) begin
            pmem_rdata = 64'h1111_1111_1111_1111 * (k + 1);
            pmem_resp = 1'b1;
            step();
            if (k < 3) chk("c_no_resp_yet", ch_resp, 0);
        end
        chk("c_resp", ch_resp, 3'b001);
        chk("c_rdata", ch_rdata, rl);
        chk("c_read_drop", pmem_read, 0);
        ch_read = '0; pmem_resp = 1'b0;
        step();
        chk("c_resp_pulse", ch_resp, 0);
        chk("c_rdata_hold", ch_rdata, rl);

        // write ch1 with two-cycle gaps between responses
        ch_write = 3'b010;
        ch_address[32 +: 32] = 32'h2000_0047;
        ch_wdata[256 +: 256] = {wb[3], wb[2], wb[1], wb[0]};
        step();
        chk("d_write", pmem_write, 1);
        chk("d_read", pmem_read, 0);
        chk("d_addr", pmem_address, 32'h2000_0040);
        for (int k = 0; k < 4; k++) begin
            chk("d_wbeat", pmem_wdata, wb[k]);
            step();
            chk("d_whold1", pmem_wdata, wb[k]);
            step();
            chk("d_whold2", pmem_wdata, wb[k]);
            chk("d_wresp_wait", ch_resp, 0);
            pmem_resp = 1'b1;
            step();
            pmem_resp = 1'b0;
        end
        chk("d_resp", ch_resp, 3'b010);
        chk("d_rdata_keep", ch_rdata, rl);
        chk("d_write_drop", pmem_write, 0);
        ch_write = '0;
        step();

        // read and write together on ch0: write wins
        ch_read = 3'b001; ch_write = 3'b001;
        ch_wdata[0 +: 256] = {64'h8888, 64'h7777, 64'h6666, 64'h5555};
        step();
        chk("e_write", pmem_write, 1);
        chk("e_read", pmem_read, 0);
        chk("e_wbeat0", pmem_wdata, 64'h5555);
        pmem_resp = 1'b1;
        step();
        chk("e_wbeat1", pmem_wdata, 64'h6666);
        step(); step(); step();
        chk("e_resp", ch_resp, 3'b001);
        chk("e_rdata_keep", ch_rdata, rl);
        ch_read = '0; ch_write = '0; pmem_resp = 1'b0;
        step();

        // contention: all channels continuously requesting from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("f_rst_rdata", ch_rdata, 0);
        ch_read = 3'b111;
        ch_address = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        pmem_resp = 1'b1;
        for (int b = 0; b < 6; b++) begin
            step();
            chk("f_grant_addr", pmem_address, 32'h1000 * ((b % 3) + 1));
            chk("f_read", pmem_read, 1);
            step(); step(); step();
            chk("f_no_resp", ch_resp, 0);
            step();
            chk("f_resp", ch_resp, 3'b001 << (b % 3));
            step();
            chk("f_idle_gap", pmem_read, 0);
            chk("f_resp_clear", ch_resp, 0);
        end
        ch_read = '0; pmem_resp = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pmem_arbiter_rr.md
Name: pmem_arbiter_rr

Overview:
Parametrised N-channel physical-memory arbiter with cacheline burst conversion, between the cache hierarchy and the single 64-bit burst pmem port.
- Generalises today's fixed two-client (I/D) cache-to-pmem path to NUM_CH requesters, e.g. I-cache, D-cache and prefetcher.
- Each requester presents a full-line request; the block grants round-robin and runs the burst of BEATS beats.
- Read data is assembled into a line register; write data is serialised beat by beat.

Parameters:
NUM_CH, 2, number of requesting channels (>=1)
ADDR_W, 32, address width
LINE_W, 256, cacheline width in bits
BEAT_W, 64, pmem beat width; BEATS = LINE_W/BEAT_W, must be an integer power of two

Ports:
clk  in  1  clock
rst  in  1  reset
ch_read  in  NUM_CH  per-channel line read request
ch_write  in  NUM_CH  per-channel line write request
ch_address  in  NUM_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  NUM_CH*LINE_W  per-channel write line
ch_rdata  out  LINE_W  shared read line, valid only with ch_resp
ch_resp  out  NUM_CH  one-hot completion pulse
pmem_read  out  1  burst read request
pmem_write  out  1  burst write request
pmem_address  out  ADDR_W  line-aligned burst address
pmem_wdata  out  BEAT_W  current write beat
pmem_rdata  in  BEAT_W  current read beat
pmem_resp  in  1  one beat accepted/returned

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
Reset (rst=1 at a clock edge):
- State goes to IDLE; beat counter 0; last_grant = NUM_CH-1, so channel 0 has first priority.
- All outputs are 0, including ch_rdata.
- Reset during BURST aborts the burst: pmem_read/pmem_write are low from the next cycle and no ch_resp is issued.

State machine IDLE -> BURST -> DONE -> IDLE.

IDLE:
- req[i] = ch_read[i] | ch_write[i].
- If any req, grant the first requesting channel searching from last_grant+1 upward, mod NUM_CH.
- Latch grant, op, and the address with its low log2(LINE_W/8) bits forced to 0.
- If ch_write[grant] is set, op is write (write wins if both read and write are set) and ch_wdata of that channel is latched.
- Go to BURST. No pmem outputs are asserted while in IDLE.

BURST:
- pmem_read or pmem_write is held high per op; pmem_address is held constant at the latched value.
- pmem_wdata = latched line beat[cnt], where beat k = bits [k*BEAT_W +: BEAT_W].
- On pmem_resp, a read stores pmem_rdata into rdata beat[cnt], then cnt increments.
- On the resp for beat BEATS-1: cnt wraps to 0, pmem request drops the next cycle, go to DONE.
- pmem_resp seen in IDLE/DONE is ignored.

DONE (exactly one cycle):
- ch_resp[grant]=1; ch_rdata = assembled line for reads, and holds its last value for writes.
- last_grant <= grant; go to IDLE.

Latency and fairness:
- Request seen in IDLE at cycle t: pmem request from t+1.
- With pmem_resp high every cycle, ch_resp is at t+BEATS+1 (t+5 by default).
- Back-to-back: the IDLE cycle after DONE re-arbitrates, so there is one idle pmem cycle between bursts.
- Fairness: a channel continuously requesting waits at most NUM_CH-1 bursts.

Requester rules:
- Hold request, address and wdata until ch_resp; drop the request the cycle after ch_resp.
- A request deasserted mid-burst does not abort the burst; ch_resp is still pulsed.
- Inputs of non-granted channels are ignored.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum arb_state_t {IDLE, BURST, DONE};
  - functions for BEATS and offset width.
- Sub-module rr_pick: combinational round-robin select (req vector, last_grant -> grant index, any_req), parametrised on NUM_CH.

Test Plan:
- Reset mid-burst: read in progress, rst at beat 2 -> pmem_read low next cycle, no ch_resp, next request granted to channel 0 first.
- Single read, ch0, addr 0x0000_1234, beats 0x11..1,0x22..2,0x33..3,0x44..4 with resp every cycle -> pmem_address 0x0000_1220, ch_resp=01 at t+5, ch_rdata = {0x44..4,0x33..3,0x22..2,0x11..1}.
- Write, ch1, line 0xDDDD..CCCC..BBBB..AAAA, pmem_resp with 2-cycle gaps -> pmem_wdata steps AAAA,BBBB,CCCC,DDDD, each held until its resp; ch_resp=10 one cycle after 4th resp.
- Contention, NUM_CH=3, all channels requesting continuously -> grant order 0,1,2,0,1,2; one idle cycle between bursts; each ch_resp one-hot.
- ch_read and ch_write both high on ch0 -> write burst performed, no read burst.
